// File: rtl/chopper_demodulator_pkg.sv
// Shared definitions for the chopper demodulator and the chopper generator side:
// phase encodings, FSM states, default widths and the forward phase sequence.
package chopper_demodulator_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 40;

  // Encoded as {ref1, ref2}
  typedef enum logic [1:0] {
    P0 = 2'b00,
    P1 = 2'b10,
    P2 = 2'b11,
    P3 = 2'b01
  } phase_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARM       = 2'd1,
    S_INTEGRATE = 2'd2
  } state_e;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      P0:      return P1;
      P1:      return P2;
      P2:      return P3;
      default: return P0;
    endcase
  endfunction

endpackage

// File: rtl/chopper_phase_tracker.sv
// Synchronizes the chopper references, classifies each phase change and
// runs the loss-of-lock watchdog.
module chopper_phase_tracker
  import chopper_demodulator_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk_in,
  input  logic rst,
  input  logic ref1_i,
  input  logic ref2_i,
  output logic r1_o,
  output logic r2_o,
  output logic step_c,
  output logic boundary_c,
  output logic illegal_c,
  output logic timeout_c
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [1:0]      meta_q;
  logic [1:0]      sync_q;
  phase_e          prev_q;
  phase_e          cur;
  logic            changed;
  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;

  assign cur        = phase_e'(sync_q);
  assign changed    = (cur != prev_q);
  assign step_c     = changed && (cur == next_phase(prev_q));
  assign illegal_c  = changed && !step_c;
  assign boundary_c = (prev_q == P3) && (cur == P0);
  assign timeout_c  = !changed && (wd_q == WD_W'(TIMEOUT));
  assign r1_o       = sync_q[1];
  assign r2_o       = sync_q[0];

  // Cycles since the last phase change; parks at TIMEOUT until the next change
  always_comb begin
    wd_d = wd_q;
    if (changed) begin
      wd_d = '0;
    end else if (wd_q != WD_W'(TIMEOUT)) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= P0;
      wd_q   <= '0;
    end else begin
      meta_q <= {ref1_i, ref2_i};
      sync_q <= meta_q;
      prev_q <= cur;
      wd_q   <= wd_d;
    end
  end

endmodule

// File: rtl/chopper_demodulator.sv
// Lock-in demodulator: integrates +/- samples against the in-phase and quadrature
// chopper references over N_PERIODS reference periods. ACC_W must exceed DATA_W.
module chopper_demodulator
  import chopper_demodulator_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned N_PERIODS = 16,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     ref1,
  input  logic                     ref2,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_data,
  output logic signed [ACC_W-1:0]  i_out,
  output logic signed [ACC_W-1:0]  q_out,
  output logic                     out_valid,
  output logic                     locked,
  output logic                     seq_err,
  output logic                     sat
);

  localparam int unsigned CNT_W = $clog2(N_PERIODS + 1);

  logic r1, r2, step, boundary, illegal, timeout;

  chopper_phase_tracker #(.TIMEOUT(TIMEOUT)) u_tracker (
    .clk_in     (clk_in),
    .rst        (rst),
    .ref1_i     (ref1),
    .ref2_i     (ref2),
    .r1_o       (r1),
    .r2_o       (r2),
    .step_c     (step),
    .boundary_c (boundary),
    .illegal_c  (illegal),
    .timeout_c  (timeout)
  );

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sticky_q, sticky_d;
  logic signed [ACC_W-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;
  logic                     out_valid_q, out_valid_d, locked_q, locked_d;
  logic                     seq_err_q, seq_err_d, sat_q, sat_d;

  logic signed [ACC_W-1:0]  op, neg_op, sum_i, sum_q;
  logic                     ovf_i, ovf_q;

  assign op     = ACC_W'(sample_data);
  assign neg_op = -op;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic                    ovf
  );
    logic signed [ACC_W:0] s;
    s   = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    ovf = (s[ACC_W] != s[ACC_W-1]);
    if (!ovf) return s[ACC_W-1:0];
    return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    sum_i       = acc_i_q;
    sum_q       = acc_q_q;
    ovf_i       = 1'b0;
    ovf_q       = 1'b0;

    if (sample_valid) begin
      sum_i = sat_add(acc_i_q, r1 ? op : neg_op, ovf_i);
      sum_q = sat_add(acc_q_q, r2 ? op : neg_op, ovf_q);
    end

    // A broken sequence aborts the window before any completion can be reported
    if (illegal || (timeout && (state_q != S_IDLE))) begin
      seq_err_d = 1'b1;
      state_d   = S_IDLE;
      acc_i_d   = '0;
      acc_q_d   = '0;
      cnt_d     = '0;
      sticky_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (step) state_d = S_ARM;
        S_ARM:  if (boundary) state_d = S_INTEGRATE;
        S_INTEGRATE: begin
          if (boundary && (cnt_q == CNT_W'(N_PERIODS - 1))) begin
            i_out_d     = sum_i;
            q_out_d     = sum_q;
            out_valid_d = 1'b1;
            sat_d       = sticky_q | ovf_i | ovf_q;
            acc_i_d     = '0;
            acc_q_d     = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
          end else begin
            acc_i_d  = sum_i;
            acc_q_d  = sum_q;
            sticky_d = sticky_q | ovf_i | ovf_q;
            if (boundary) cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    locked_d = (state_d == S_INTEGRATE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      sat_q       <= sat_d;
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign locked    = locked_q;
  assign seq_err   = seq_err_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_chopper_demodulator.sv
// Bench for chopper_demodulator: three parameterisations share one stimulus stream
// and are scored every cycle against a window-level behavioural model.
module tb_chopper_demodulator;

  localparam int TO = 50;

  logic clk_in = 1'b0;
  logic rst, ref1, ref2, sample_valid;
  logic signed [15:0] sample_data;
  logic signed [39:0] i0, q0, i1, q1;
  logic signed [19:0] i2, q2;
  logic [2:0] ov, lk, er, st;

  always #5 clk_in = ~clk_in;

  chopper_demodulator #(.DATA_W(16), .ACC_W(40), .N_PERIODS(2), .TIMEOUT(TO)) dut0 (
    .clk_in(clk_in), .rst(rst), .ref1(ref1), .ref2(ref2), .sample_valid(sample_valid),
    .sample_data(sample_data), .i_out(i0), .q_out(q0), .out_valid(ov[0]), .locked(lk[0]),
    .seq_err(er[0]), .sat(st[0]));
  chopper_demodulator #(.DATA_W(16), .ACC_W(40), .N_PERIODS(1), .TIMEOUT(TO)) dut1 (
    .clk_in(clk_in), .rst(rst), .ref1(ref1), .ref2(ref2), .sample_valid(sample_valid),
    .sample_data(sample_data), .i_out(i1), .q_out(q1), .out_valid(ov[1]), .locked(lk[1]),
    .seq_err(er[1]), .sat(st[1]));
  chopper_demodulator #(.DATA_W(16), .ACC_W(20), .N_PERIODS(8), .TIMEOUT(TO)) dut2 (
    .clk_in(clk_in), .rst(rst), .ref1(ref1), .ref2(ref2), .sample_valid(sample_valid),
    .sample_data(sample_data), .i_out(i2), .q_out(q2), .out_valid(ov[2]), .locked(lk[2]),
    .seq_err(er[2]), .sat(st[2]));

  int vecs = 0, errs = 0, cyc = 0, cur_ph = 0;
  int h0, h1, h2, h3;                  // driven phase history, h0 = newest
  int m_st[3], m_cnt[3], m_nc[3];      // model mode: 0 idle, 1 arm, 2 integrate
  longint m_ai[3], m_aq[3], m_io[3], m_qo[3];
  bit m_stk[3], m_ov[3], m_lk[3], m_er[3], m_sat[3];
  int err_seen[3];

  typedef struct {int k; longint i; longint q; bit s; bit l; int c;} obs_t;
  obs_t obsq[$];

  function automatic int np(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 8;
  endfunction

  function automatic int aw(input int k);
    return (k == 2) ? 20 : 40;
  endfunction

  function automatic longint clamp(input longint v, input int w, output bit hit);
    longint hi, lo;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    hit = 1'b0;
    if (v > hi) begin hit = 1'b1; return hi; end
    if (v < lo) begin hit = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_reset();
    h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_nc[k] = 0; m_ai[k] = 0; m_aq[k] = 0;
      m_io[k] = 0; m_qo[k] = 0; m_stk[k] = 0; m_ov[k] = 0; m_lk[k] = 0;
      m_er[k] = 0; m_sat[k] = 0;
    end
  endtask

  // Phases are numbered 0..3 in forward order; the legal successor is (p+1)%4.
  task automatic model_step(input int k, input int cur, input int prv, input bit sv, input int sd);
    bit chg, ill, bnd, tmo, hi, hq;
    longint si, sq;
    chg = (cur != prv);
    ill = chg && (cur != (prv + 1) % 4);
    bnd = (prv == 3) && (cur == 0);
    tmo = !chg && (m_nc[k] >= TO);
    m_nc[k] = chg ? 0 : ((m_nc[k] > TO) ? m_nc[k] : m_nc[k] + 1);
    m_ov[k] = 0; m_er[k] = 0;
    if (ill || (tmo && m_st[k] != 0)) begin
      m_er[k] = 1; m_st[k] = 0; m_ai[k] = 0; m_aq[k] = 0; m_cnt[k] = 0; m_stk[k] = 0;
    end else if (m_st[k] == 0) begin
      if (chg) m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      if (bnd) m_st[k] = 2;
    end else begin
      si = m_ai[k]; sq = m_aq[k]; hi = 0; hq = 0;
      if (sv) begin
        si = clamp(m_ai[k] + ((cur == 1 || cur == 2) ? sd : -sd), aw(k), hi);
        sq = clamp(m_aq[k] + ((cur >= 2) ? sd : -sd), aw(k), hq);
      end
      if (bnd && (m_cnt[k] + 1 == np(k))) begin
        m_io[k] = si; m_qo[k] = sq; m_ov[k] = 1; m_sat[k] = m_stk[k] | hi | hq;
        m_ai[k] = 0; m_aq[k] = 0; m_cnt[k] = 0; m_stk[k] = 0;
      end else begin
        m_ai[k] = si; m_aq[k] = sq; m_stk[k] = m_stk[k] | hi | hq;
        if (bnd) m_cnt[k] = m_cnt[k] + 1;
      end
    end
    m_lk[k] = (m_st[k] == 2);
  endtask

  // Drive one clock of stimulus, advance the model and score all three DUTs
  task automatic drive_cycle(input int ph, input bit sv, input logic signed [15:0] sd);
    ref1 = (ph == 1 || ph == 2);
    ref2 = (ph >= 2);
    sample_valid = sv;
    sample_data = sd;
    h3 = h2; h2 = h1; h1 = h0; h0 = ph;
    for (int k = 0; k < 3; k++) model_step(k, h2, h3, sv, int'(sd));
    @(posedge clk_in); #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      logic signed [63:0] ai, aq;
      case (k)
        0: begin ai = i0; aq = q0; end
        1: begin ai = i1; aq = q1; end
        default: begin ai = i2; aq = q2; end
      endcase
      vecs++;
      if ({ov[k], lk[k], er[k], st[k]} !== {m_ov[k], m_lk[k], m_er[k], m_sat[k]}) begin
        errs++;
        $display("FAIL flags dut%0d cyc %0d got ov/lk/err/sat=%b%b%b%b expected %b%b%b%b", k, cyc,
                 ov[k], lk[k], er[k], st[k], m_ov[k], m_lk[k], m_er[k], m_sat[k]);
      end
      vecs++;
      if (ai !== m_io[k] || aq !== m_qo[k]) begin
        errs++;
        $display("FAIL result dut%0d cyc %0d got i=%0d q=%0d expected i=%0d q=%0d", k, cyc,
                 ai, aq, m_io[k], m_qo[k]);
      end
      if (er[k] === 1'b1) err_seen[k]++;
      if (ov[k] === 1'b1) obsq.push_back('{k, longint'(ai), longint'(aq), st[k], lk[k], cyc});
    end
  endtask

  // sp is the synchronized phase that the DUT pairs with the sample driven now
  task automatic sample_for(input int mode, input int sp, output bit sv, output logic signed [15:0] sd);
    case (mode)
      0: begin sv = 1'b1; sd = 16'sd100; end
      1: begin sv = (sp == 1); sd = 16'sd100; end
      2: begin sv = (sp == 1 || sp == 2); sd = 16'sd32767; end
      4: begin sv = (sp == 0); sd = -16'sd32768; end
      default: begin
        sv = 1'($urandom_range(0, 1));
        sd = 16'($urandom);
        if ($urandom_range(0, 7) == 0) sd = -16'sd32768;
      end
    endcase
  endtask

  task automatic run_phases(input int nph, input int cpp, input int mode);
    bit sv;
    logic signed [15:0] sd;
    for (int p = 0; p < nph; p++) begin
      cur_ph = (cur_ph + 1) % 4;
      for (int c = 0; c < cpp; c++) begin
        sample_for(mode, h1, sv, sd);
        drive_cycle(cur_ph, sv, sd);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ref1 = 1'b0; ref2 = 1'b0; sample_valid = 1'b0; sample_data = '0;
    cur_ph = 0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    vecs++;
    if ({i0, q0, i1, q1, i2, q2} !== '0 || {ov, lk, er, st} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got ov=%b lk=%b err=%b sat=%b i0=%0d expected all zero", ov, lk, er, st, i0);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_sum();
    int n = 0;
    obsq.delete();
    run_phases(24, 4, 0);
    foreach (obsq[j]) if (obsq[j].k == 0) begin
      n++;
      vecs++;
      if (obsq[j].i != 0 || obsq[j].q != 0 || !obsq[j].l) begin
        errs++;
        $display("FAIL zero_sum got i=%0d q=%0d locked=%b expected 0 0 1", obsq[j].i, obsq[j].q, obsq[j].l);
      end
    end
    vecs++;
    if (n < 2) begin errs++; $display("FAIL zero_sum_count got %0d windows expected >=2", n); end
  endtask

  task automatic test_window_const(input string nm, input int mode, input int nph, input int k,
                                   input longint ei, input longint eq, input bit es);
    int n = 0;
    obsq.delete();
    run_phases(nph, 4, mode);
    foreach (obsq[j]) if (obsq[j].k == k) begin
      n++;
      // the first completion may straddle the previous stimulus pattern
      if (n > 1) begin
        vecs++;
        if (obsq[j].i != ei || obsq[j].q != eq || obsq[j].s != es) begin
          errs++;
          $display("FAIL %s got i=%0d q=%0d sat=%b expected i=%0d q=%0d sat=%b", nm,
                   obsq[j].i, obsq[j].q, obsq[j].s, ei, eq, es);
        end
      end
    end
    vecs++;
    if (n < 2) begin errs++; $display("FAIL %s_count got %0d windows expected >=2", nm, n); end
  endtask

  task automatic test_skip();
    int n = 0;
    run_phases(12, 4, 0);
    err_seen = '{0, 0, 0};
    cur_ph = (cur_ph + 2) % 4;
    repeat (3) drive_cycle(cur_ph, 1'b1, 16'sd100);
    vecs++;
    if (err_seen[0] != 1 || lk[0] !== 1'b0) begin
      errs++;
      $display("FAIL skip_err got seq_err count=%0d locked=%b expected 1 0", err_seen[0], lk[0]);
    end
    obsq.delete();
    run_phases(16, 4, 0);
    foreach (obsq[j]) if (obsq[j].k == 0) n++;
    vecs++;
    if (lk[0] !== 1'b1 || n < 1) begin
      errs++;
      $display("FAIL relock got locked=%b windows=%0d expected 1 >=1", lk[0], n);
    end
  endtask

  task automatic test_timeout();
    run_phases(12, 4, 0);
    while (cur_ph != 2) run_phases(1, 4, 0);
    vecs++;
    if (lk[0] !== 1'b1) begin errs++; $display("FAIL pre_freeze_lock got %b expected 1", lk[0]); end
    err_seen = '{0, 0, 0};
    repeat (60) drive_cycle(cur_ph, 1'b1, 16'sd100);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (err_seen[k] != 1 || lk[k] !== 1'b0) begin
        errs++;
        $display("FAIL timeout dut%0d got seq_err count=%0d locked=%b expected 1 0", k, err_seen[k], lk[k]);
      end
    end
  endtask

  task automatic test_random();
    int n_ill = 0, r;
    bit sv;
    logic signed [15:0] sd;
    err_seen = '{0, 0, 0};
    for (int p = 0; p < 60; p++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin cur_ph = (cur_ph + 2) % 4; n_ill++; end
      else if (r == 1) begin cur_ph = (cur_ph + 3) % 4; n_ill++; end
      else cur_ph = (cur_ph + 1) % 4;
      for (int c = 0; c < $urandom_range(1, 6); c++) begin
        sample_for(3, h1, sv, sd);
        drive_cycle(cur_ph, sv, sd);
      end
    end
    repeat (3) drive_cycle(cur_ph, 1'b0, 16'sd0);
    vecs++;
    if (err_seen[0] != n_ill) begin
      errs++;
      $display("FAIL random_seq_err got %0d pulses expected %0d", err_seen[0], n_ill);
    end
  endtask

  task automatic test_reset_mid();
    int rel, f0 = -1, f2 = -1;
    run_phases(6, 4, 0);
    rst = 1'b1;
    #1;
    vecs++;
    if ({i0, q0, i1, q1, i2, q2} !== '0 || {ov, lk, er, st} !== '0) begin
      errs++;
      $display("FAIL reset_mid_outputs got ov=%b lk=%b err=%b sat=%b expected all zero", ov, lk, er, st);
    end
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;
    rel = cyc;
    obsq.delete();
    run_phases(44, 4, 0);
    foreach (obsq[j]) begin
      if (obsq[j].k == 0 && f0 < 0) f0 = obsq[j].c - rel;
      if (obsq[j].k == 2 && f2 < 0) f2 = obsq[j].c - rel;
    end
    vecs++;
    if (f0 < 32 || f2 < 128) begin
      errs++;
      $display("FAIL reset_mid_first_valid got dut0=%0d dut2=%0d cycles expected >=32 >=128", f0, f2);
    end
  endtask

  initial begin
    test_reset();
    test_zero_sum();
    test_window_const("p1_only", 1, 16, 1, 400, -400, 1'b0);
    test_window_const("neg_min", 4, 12, 1, 131072, 131072, 1'b0);
    test_window_const("saturate", 2, 80, 2, 524287, 0, 1'b1);
    test_skip();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
